// File: rtl/sysid_check_master.sv
// sysid_check_master: Avalon-MM read initiator that fetches the sysid ID word
// (addr 0) and build timestamp (addr 1), latches both and compares them.
// Ports: clock, reset (sync, active-high), start pulse; avm_address/avm_read
// out, avm_waitrequest/avm_readdata/avm_readdatavalid in; busy, done,
// id_value, ts_value, id_match, ts_match, timeout_err (all registered).
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h558A0D5F,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE
  } state_e;

  state_e      state_q, state_d;
  logic        first_q;
  logic [15:0] cnt_q, cnt_d;
  logic        in_txn, tmo, go, enter_rd;

  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        tmo_err_q, tmo_err_d;

  // first_q marks the first cycle after reset for the auto-start launch
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      cnt_q   <= cnt_d;
    end
  end

  assign in_txn = state_q inside {RD_ID, WAIT_ID, RD_TS, WAIT_TS};
  // Timeout has priority over a completion arriving in the same cycle
  assign tmo    = in_txn && (cnt_q == TIMEOUT_CYCLES);
  assign go     = start || (AUTO_START && first_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (go) state_d = RD_ID;
      RD_ID: begin
        if (tmo)                  state_d = DONE;
        else if (!avm_waitrequest) state_d = WAIT_ID;
      end
      WAIT_ID: begin
        if (tmo)                    state_d = DONE;
        else if (avm_readdatavalid) state_d = RD_TS;
      end
      RD_TS: begin
        if (tmo)                  state_d = DONE;
        else if (!avm_waitrequest) state_d = WAIT_TS;
      end
      WAIT_TS: begin
        if (tmo)                    state_d = DONE;
        else if (avm_readdatavalid) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_rd = ((state_d == RD_ID) && (state_q != RD_ID)) ||
                    ((state_d == RD_TS) && (state_q != RD_TS));

  // One counter shared by both transactions, restarted per command
  always_comb begin
    cnt_d = cnt_q;
    if (enter_rd)    cnt_d = '0;
    else if (in_txn) cnt_d = cnt_q + 16'd1;
  end

  // Outputs are derived from the next state so they register with it
  always_comb begin
    read_d     = (state_d == RD_ID) || (state_d == RD_TS);
    addr_d     = (state_d == RD_TS) || (state_d == WAIT_TS);
    busy_d     = state_d inside {RD_ID, WAIT_ID, RD_TS, WAIT_TS};
    done_d     = (state_d == DONE);
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    tmo_err_d  = tmo_err_q | tmo;
    if ((state_d == RD_ID) && (state_q != RD_ID)) begin
      id_value_d = '0;
      ts_value_d = '0;
      id_match_d = 1'b0;
      ts_match_d = 1'b0;
      tmo_err_d  = 1'b0;
    end
    if ((state_q == WAIT_ID) && (state_d == RD_TS)) begin
      id_value_d = avm_readdata;
      id_match_d = (avm_readdata == EXPECTED_ID);
    end
    if ((state_q == WAIT_TS) && (state_d == DONE) && !tmo) begin
      ts_value_d = avm_readdata;
      ts_match_d = (avm_readdata == EXPECTED_TS);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// tb_sysid_check_master: directed vector bench for sysid_check_master
// with a behavioural Avalon-MM sysid responder.
module tb_sysid_check_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        id_match;
  logic        ts_match;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  sysid_check_master #(
    .EXPECTED_ID   (32'hACD51302),
    .EXPECTED_TS   (32'h558A0D5F),
    .TIMEOUT_CYCLES(16'd8),
    .AUTO_START    (1'b1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_value         (id_value),
    .ts_value         (ts_value),
    .id_match         (id_match),
    .ts_match         (ts_match),
    .timeout_err      (timeout_err)
  );

  always #5 clock = ~clock;

  // responder configuration and state
  logic [31:0] mem0, mem1;
  int          waits_cfg, lat_cfg;
  bit          kill_cfg;
  bit          resp_en;
  int          pend, stall_left;
  bit          in_cmd, pend_addr, prev_stall, prev_addr;

  typedef struct {
    string       name;
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          waits;
    int          lat;
    bit          kill_ts;
    int          exp_lat;
    int          exp_rd;
    logic [31:0] exp_idv;
    bit          exp_idm;
    logic [31:0] exp_tsv;
    bit          exp_tsm;
    bit          exp_to;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic resp_clear();
    pend       = 0;
    stall_left = 0;
    in_cmd     = 1'b0;
    pend_addr  = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = 1'b0;
  endtask

  task automatic resp_step();
    if (!resp_en) return;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'hDEADBEEF;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend_addr ? mem1 : mem0;
      end
    end
    if (prev_stall) begin
      chk("stall_read", 32'(avm_read), 32'd1);
      chk("stall_addr", 32'(avm_address), 32'(prev_addr));
    end
    avm_waitrequest = 1'b0;
    prev_stall      = 1'b0;
    if (avm_read) begin
      if (!in_cmd) begin
        in_cmd     = 1'b1;
        stall_left = waits_cfg;
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
        prev_stall = 1'b1;
        prev_addr  = avm_address;
      end else begin
        in_cmd    = 1'b0;
        pend      = (avm_address && kill_cfg) ? 0 : lat_cfg;
        pend_addr = avm_address;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    resp_step();
  endtask

  task automatic cfg_nominal();
    mem0      = 32'hACD51302;
    mem1      = 32'h558A0D5F;
    waits_cfg = 0;
    lat_cfg   = 1;
    kill_cfg  = 1'b0;
    resp_clear();
  endtask

  initial begin
    int lat;
    int rdc;

    vecs[0] = '{"nominal", 32'hACD51302, 32'h558A0D5F, 0, 1, 1'b0,
                5, 2, 32'hACD51302, 1'b1, 32'h558A0D5F, 1'b1, 1'b0};
    vecs[1] = '{"ts_mis", 32'hACD51302, 32'h558A0D60, 0, 1, 1'b0,
                5, 2, 32'hACD51302, 1'b1, 32'h558A0D60, 1'b0, 1'b0};
    vecs[2] = '{"backp", 32'hACD51302, 32'h558A0D5F, 3, 2, 1'b0,
                13, 8, 32'hACD51302, 1'b1, 32'h558A0D5F, 1'b1, 1'b0};
    vecs[3] = '{"tmo", 32'hACD51302, 32'h558A0D5F, 0, 1, 1'b1,
                12, 2, 32'hACD51302, 1'b1, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{"id_mis", 32'hACD51303, 32'h558A0D5F, 0, 1, 1'b0,
                5, 2, 32'hACD51303, 1'b0, 32'h558A0D5F, 1'b1, 1'b0};

    reset             = 1'b1;
    start             = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    resp_en           = 1'b1;
    cfg_nominal();

    // reset values
    tick();
    tick();
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idv", id_value, 32'd0);
    chk("rst_tsv", ts_value, 32'd0);
    chk("rst_idm", 32'(id_match), 32'd0);
    chk("rst_tsm", 32'(ts_match), 32'd0);
    chk("rst_to", 32'(timeout_err), 32'd0);

    // auto start on first cycle after reset
    reset = 1'b0;
    tick();
    chk("auto_read", 32'(avm_read), 32'd1);
    chk("auto_addr", 32'(avm_address), 32'd0);
    chk("auto_busy", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk("auto_lat", 32'(lat), 32'd5);
    chk("auto_idm", 32'(id_match), 32'd1);
    chk("auto_tsm", 32'(ts_match), 32'd1);
    chk("auto_to", 32'(timeout_err), 32'd0);

    // table-driven checks
    for (int i = 0; i < 5; i++) begin
      mem0      = vecs[i].id_word;
      mem1      = vecs[i].ts_word;
      waits_cfg = vecs[i].waits;
      lat_cfg   = vecs[i].lat;
      kill_cfg  = vecs[i].kill_ts;
      resp_clear();
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      rdc = int'(avm_read);
      while (!done && lat < 100) begin
        tick();
        lat++;
        rdc += int'(avm_read);
      end
      chk({vecs[i].name, "_done"}, 32'(done), 32'd1);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_rdcnt"}, 32'(rdc), 32'(vecs[i].exp_rd));
      chk({vecs[i].name, "_idv"}, id_value, vecs[i].exp_idv);
      chk({vecs[i].name, "_idm"}, 32'(id_match), 32'(vecs[i].exp_idm));
      chk({vecs[i].name, "_tsv"}, ts_value, vecs[i].exp_tsv);
      chk({vecs[i].name, "_tsm"}, 32'(ts_match), 32'(vecs[i].exp_tsm));
      chk({vecs[i].name, "_to"}, 32'(timeout_err), 32'(vecs[i].exp_to));
      chk({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
      chk({vecs[i].name, "_read"}, 32'(avm_read), 32'd0);
    end

    // restart from DONE clears state; start while busy is ignored
    cfg_nominal();
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    chk("rs_done_clr", 32'(done), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_tsm_clr", 32'(ts_match), 32'd0);
    chk("rs_idv_clr", id_value, 32'd0);
    chk("rs_tsv_clr", ts_value, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat++;
    chk("ign_read", 32'(avm_read), 32'd0);
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd5);
    chk("ign_idm", 32'(id_match), 32'd1);
    chk("ign_tsm", 32'(ts_match), 32'd1);
    tick();
    tick();
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_read", 32'(avm_read), 32'd0);

    // reset in WAIT_ID with a late readdatavalid afterwards
    cfg_nominal();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_wait_busy", 32'(busy), 32'd1);
    chk("mid_wait_read", 32'(avm_read), 32'd0);
    reset             = 1'b1;
    resp_en           = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_read", 32'(avm_read), 32'd0);
    chk("mid_rst_idv", id_value, 32'd0);
    chk("mid_rst_idm", 32'(id_match), 32'd0);
    chk("mid_rst_to", 32'(timeout_err), 32'd0);
    reset             = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'hACD51302;
    tick();
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'hDEADBEEF;
    chk("late_idv", id_value, 32'd0);
    chk("late_idm", 32'(id_match), 32'd0);
    chk("late_read", 32'(avm_read), 32'd1);
    chk("late_addr", 32'(avm_address), 32'd0);
    resp_clear();
    resp_en = 1'b1;
    resp_step();
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk("re_lat", 32'(lat), 32'd5);
    chk("re_idm", 32'(id_match), 32'd1);
    chk("re_tsm", 32'(ts_match), 32'd1);
    chk("re_to", 32'(timeout_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
